core_ibex_instr_capture_ctrl: RTL and testbench

//  Sequences capture of ID-stage instruction events and buffers them for a single downstream trace consumer.
//  - Qualifies completions from the ID stage and pushes one record per completed instruction into a FIFO of DEPTH entries.
//  - Presents records on a valid/ready port.
//  - Checks RVFI order continuity and flags overflow / order errors.
//  - Sits between the core ID-stage probe points and the trace/scoreboard logic.

---
 rtl/core_ibex_instr_capture_ctrl_if.sv | 22 ++
 rtl/core_ibex_instr_capture_ctrl.sv | 172 +++++++++++++++++
 tb/tb_core_ibex_instr_capture_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_ibex_instr_capture_ctrl_if.sv
// Record stream between the instruction capture controller and its single trace consumer.
interface core_ibex_instr_capture_ctrl_if #(
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned RecW = 3 * DataWidth + 83;

  logic            rec_valid_o;
  logic            rec_ready_i;
  logic [RecW-1:0] rec_o;

  modport master (
    output rec_valid_o,
    output rec_o,
    input  rec_ready_i
  );

  modport slave (
    input  rec_valid_o,
    input  rec_o,
    output rec_ready_i
  );
endinterface

// File: rtl/core_ibex_instr_capture_ctrl.sv
// Captures completed ID-stage instructions into a small FIFO for a trace consumer,
// tracking RVFI order continuity and overflow.
module core_ibex_instr_capture_ctrl #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter bit          HaltOnOvf = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic                         valid_id_i,
  input  logic                         id_done_i,
  input  logic                         stall_id_i,
  input  logic                         err_id_i,
  input  logic                         is_compressed_i,
  input  logic [15:0]                  instr_c_i,
  input  logic [DataWidth-1:0]         instr_i,
  input  logic [DataWidth-1:0]         pc_i,
  input  logic                         branch_taken_i,
  input  logic [DataWidth-1:0]         branch_target_i,
  input  logic [63:0]                  order_i,
  core_ibex_instr_capture_ctrl_if.master rec_if,
  output logic [$clog2(Depth+1)-1:0]   level_o,
  output logic                         ovf_o,
  output logic                         order_err_o,
  output logic [15:0]                  drop_cnt_o,
  output logic [1:0]                   state_o
);

  localparam int unsigned RecW = 3 * DataWidth + 83;
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth + 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [RecW-1:0] r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [LvlW-1:0] r_level;
  logic [LvlW-1:0] w_level_nxt;
  logic            r_valid;
  logic            r_ovf;
  logic            r_order_err;
  logic [15:0]     r_drop_cnt;
  logic [63:0]     r_last_order;

  logic            w_cap;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_order_bad;
  logic [RecW-1:0] w_rec;

  assign w_rec = {order_i, pc_i, instr_i, instr_c_i, branch_target_i,
                  branch_taken_i, is_compressed_i, err_id_i};

  assign w_cap  = en_i & valid_id_i & id_done_i & ~stall_id_i & (r_state != ST_HALT);
  assign w_full = (r_level == LvlFull);
  assign w_pop  = r_valid & rec_if.rec_ready_i;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign w_push = w_cap & ~clear_i & (~w_full | w_pop);
  assign w_drop = w_cap & ~clear_i & w_full & ~w_pop;
  assign w_order_bad = w_cap & ~clear_i & (r_state == ST_RUN) &
                       (order_i != (r_last_order + 64'd1));

  // Next-state selection for the capture sequencer.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cap) w_state_nxt = ST_RUN;
          else       w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (w_drop && HaltOnOvf) w_state_nxt = ST_HALT;
          else                     w_state_nxt = ST_RUN;
        end
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LvlW'(1);
      2'b01:   w_level_nxt = r_level - LvlW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO bookkeeping; clear discards content and any coincident push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      else        r_wr_ptr <= r_wr_ptr;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      else        r_rd_ptr <= r_rd_ptr;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != LvlW'(0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  // Sticky status and order tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf        <= 1'b0;
      r_order_err  <= 1'b0;
      r_drop_cnt   <= 16'd0;
      r_last_order <= 64'd0;
    end else if (clear_i) begin
      r_ovf        <= 1'b0;
      r_order_err  <= 1'b0;
      r_drop_cnt   <= 16'd0;
      r_last_order <= r_last_order;
    end else begin
      r_ovf       <= r_ovf | w_drop;
      r_order_err <= r_order_err | w_order_bad;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      else                                    r_drop_cnt <= r_drop_cnt;
      if (w_cap) r_last_order <= order_i;
      else       r_last_order <= r_last_order;
    end
  end

  assign rec_if.rec_valid_o = r_valid;
  assign rec_if.rec_o       = r_valid ? r_mem[r_rd_ptr] : '0;
  assign level_o            = r_level;
  assign ovf_o              = r_ovf;
  assign order_err_o        = r_order_err;
  assign drop_cnt_o         = r_drop_cnt;
  assign state_o            = r_state;

endmodule

// File: tb/tb_core_ibex_instr_capture_ctrl.sv
// Self-checking bench: two controllers (HaltOnOvf 0 and 1) on shared stimulus against a queue model.
module tb_core_ibex_instr_capture_ctrl;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int RW  = 3 * DW + 83;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en, clr, vld, done, stall, errb, isc, br, rdy;
  logic [15:0]   instr_c;
  logic [DW-1:0] instr, pc, tgt;
  logic [63:0]   ord;

  logic [2:0]    lvl   [2];
  logic          ovf   [2];
  logic          oerr  [2];
  logic [15:0]   drop  [2];
  logic [1:0]    st    [2];

  core_ibex_instr_capture_ctrl_if #(.DataWidth(DW)) rif0 ();
  core_ibex_instr_capture_ctrl_if #(.DataWidth(DW)) rif1 ();
  assign rif0.rec_ready_i = rdy;
  assign rif1.rec_ready_i = rdy;

  core_ibex_instr_capture_ctrl #(.DataWidth(DW), .Depth(DEP), .HaltOnOvf(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr), .valid_id_i(vld),
    .id_done_i(done), .stall_id_i(stall), .err_id_i(errb), .is_compressed_i(isc),
    .instr_c_i(instr_c), .instr_i(instr), .pc_i(pc), .branch_taken_i(br),
    .branch_target_i(tgt), .order_i(ord), .rec_if(rif0.master), .level_o(lvl[0]),
    .ovf_o(ovf[0]), .order_err_o(oerr[0]), .drop_cnt_o(drop[0]), .state_o(st[0]));

  core_ibex_instr_capture_ctrl #(.DataWidth(DW), .Depth(DEP), .HaltOnOvf(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr), .valid_id_i(vld),
    .id_done_i(done), .stall_id_i(stall), .err_id_i(errb), .is_compressed_i(isc),
    .instr_c_i(instr_c), .instr_i(instr), .pc_i(pc), .branch_taken_i(br),
    .branch_target_i(tgt), .order_i(ord), .rec_if(rif1.master), .level_o(lvl[1]),
    .ovf_o(ovf[1]), .order_err_o(oerr[1]), .drop_cnt_o(drop[1]), .state_o(st[1]));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: k selects HaltOnOvf = k. FIFO held as a shift list, head at index 0.
  logic [RW-1:0] mq    [2][DEP];
  int            mn    [2];
  logic [63:0]   mlast [2];
  int            mst   [2];
  bit            movf  [2];
  bit            merr  [2];
  int            mdrop [2];

  task automatic chk(input string nm, input int k, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mlast[k] = 64'd0; mst[k] = 0;
      movf[k] = 1'b0; merr[k] = 1'b0; mdrop[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [RW-1:0] rec;
    bit cap, pop, was_full;
    rec = {ord, pc, instr, instr_c, tgt, br, isc, errb};
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        mn[k] = 0; mst[k] = 0; movf[k] = 1'b0; merr[k] = 1'b0; mdrop[k] = 0;
      end else begin
        cap      = en && vld && done && !stall && (mst[k] != 2);
        pop      = (mn[k] > 0) && rdy;
        was_full = (mn[k] == DEP);
        if (pop) begin
          for (int i = 0; i < DEP - 1; i++) mq[k][i] = mq[k][i+1];
          mn[k]--;
        end
        if (cap) begin
          if (was_full && !pop) begin
            movf[k] = 1'b1;
            if (mdrop[k] < 65535) mdrop[k]++;
          end else begin
            mq[k][mn[k]] = rec;
            mn[k]++;
          end
          if (mst[k] == 1 && ord != mlast[k] + 64'd1) merr[k] = 1'b1;
          mlast[k] = ord;
          if (mst[k] == 0) mst[k] = 1;
          else if (was_full && !pop && k == 1) mst[k] = 2;
        end
      end
    end
  endtask

  task automatic compare();
    logic [RW-1:0] rv;
    logic          vv;
    for (int k = 0; k < 2; k++) begin
      rv = (k == 0) ? rif0.rec_o : rif1.rec_o;
      vv = (k == 0) ? rif0.rec_valid_o : rif1.rec_valid_o;
      chk("rec_valid", k, vv, mn[k] != 0);
      chk("level", k, lvl[k], mn[k]);
      chk("ovf", k, ovf[k], movf[k]);
      chk("order_err", k, oerr[k], merr[k]);
      chk("drop_cnt", k, drop[k], mdrop[k]);
      chk("state", k, st[k], mst[k]);
      if (mn[k] != 0) chk("rec", k, rv, mq[k][0]);
    end
  endtask

  // One clock: drive at negedge, model and compare just after the rising edge.
  task automatic cyc(input bit e, v, d, s, c, r, input logic [63:0] o);
    en = e; vld = v; done = d; stall = s; clr = c; rdy = r; ord = o;
    pc = $urandom; instr = $urandom; tgt = $urandom; instr_c = 16'($urandom);
    br = 1'($urandom); isc = 1'($urandom); errb = 1'($urandom);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1 compare();
    @(negedge clk);
  endtask

  task automatic capn(input logic [63:0] o, input bit r);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r, o);
  endtask

  task automatic idle(input bit r);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r, 64'd0);
  endtask

  task automatic clear_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
  endtask

  logic [63:0] next_ord;
  bit          e, v, d, s, c, r;
  logic [63:0] o;

  initial begin
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    rst_n = 1'b1;
    chk("rst_level", 0, lvl[0], 3'd0);
    chk("rst_valid", 0, rif0.rec_valid_o, 1'b0);
    chk("rst_rec", 0, rif0.rec_o, {RW{1'b0}});
    chk("rst_state", 1, st[1], 2'd0);

    // Orders 5,6,7 with consumer always ready
    capn(64'd5, 1'b1);
    chk("a_valid_lat1", 0, rif0.rec_valid_o, 1'b1);
    chk("a_level1", 0, lvl[0], 3'd1);
    capn(64'd6, 1'b1);
    capn(64'd7, 1'b1);
    chk("a_head_order", 0, rif0.rec_o[RW-1 -: 64], 64'd7);
    chk("a_state_run", 0, st[0], 2'd1);
    chk("a_no_order_err", 0, oerr[0], 1'b0);
    idle(1'b1);
    chk("a_drained", 0, lvl[0], 3'd0);

    // Five captures with consumer stalled: one overflow
    for (int i = 8; i <= 12; i++) capn(64'(i), 1'b0);
    chk("b_level_full", 0, lvl[0], 3'd4);
    chk("b_ovf", 0, ovf[0], 1'b1);
    chk("b_drop1", 0, drop[0], 16'd1);
    chk("b_state_run", 0, st[0], 2'd1);
    chk("b_state_halt", 1, st[1], 2'd2);
    chk("b_head_order", 0, rif0.rec_o[RW-1 -: 64], 64'd8);
    capn(64'd13, 1'b0);
    chk("b_drop2", 0, drop[0], 16'd2);
    chk("b_halt_ignores", 1, drop[1], 16'd1);

    // Clear wins over a coincident capture
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd14);
    chk("c_level", 0, lvl[0], 3'd0);
    chk("c_valid", 1, rif1.rec_valid_o, 1'b0);
    chk("c_ovf", 0, ovf[0], 1'b0);
    chk("c_drop", 0, drop[0], 16'd0);
    chk("c_state", 1, st[1], 2'd0);

    // Full FIFO with simultaneous capture and pop
    for (int i = 20; i <= 23; i++) capn(64'(i), 1'b0);
    capn(64'd24, 1'b1);
    chk("d_level_keep", 0, lvl[0], 3'd4);
    chk("d_no_ovf", 1, ovf[1], 1'b0);
    chk("d_head_order", 0, rif0.rec_o[RW-1 -: 64], 64'd21);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Order gap 11 -> 13
    clear_cyc();
    capn(64'd10, 1'b1);
    capn(64'd11, 1'b1);
    chk("e_no_err_yet", 0, oerr[0], 1'b0);
    capn(64'd13, 1'b1);
    chk("e_order_err", 0, oerr[0], 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 64-bit order wrap is legal
    clear_cyc();
    capn(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    capn(64'd0, 1'b1);
    chk("f_wrap_ok", 0, oerr[0], 1'b0);
    chk("f_wrap_ok", 1, oerr[1], 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall and disable suppress capture
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd1);
    chk("g_stall_nopush", 0, lvl[0], 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd1);
    chk("g_dis_nopush", 0, lvl[0], 3'd0);

    // Randomized traffic with an async reset mid-burst
    next_ord = 64'd2;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        capn(next_ord, 1'b0);
        capn(next_ord + 64'd1, 1'b0);
        next_ord = next_ord + 64'd2;
        chk("h_pre_nonempty", 0, lvl[0] != 3'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("h_async_level", 0, lvl[0], 3'd0);
        chk("h_async_valid", 0, rif0.rec_valid_o, 1'b0);
        chk("h_async_state", 1, st[1], 2'd0);
        idle(1'b0);
        rst_n = 1'b1;
      end
      e = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 63) == 0);
      r = 1'($urandom);
      o = ($urandom_range(0, 15) == 0) ? {32'($urandom), 32'($urandom)} : next_ord;
      if (e && v && d && !s) next_ord = o + 64'd1;
      cyc(e, v, d, s, c, r, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
